// File: rtl/i2c_cmd_arb.sv
// i2c_cmd_arb: arbitrates two command sources onto a single I2C master.
//   Requester 0 (config sequencer) has a one-deep pending slot and fixed priority.
//   Requester 1 (runtime) is buffered in a FIFO_DEPTH-entry FIFO.
//   Commands are {reg addr[15:8], data[7:0]}. No preemption: a granted transfer
//   runs until i2c_done (or the optional watchdog) before the next grant.
//
// Optional feature: define I2C_ARB_TIMEOUT_EN to enable the WAIT-state watchdog
//   (aborts after TIMEOUT_CYC cycles). Without it, timeout is tied low and no
//   counter exists.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req0_exec/req0_data    requester-0 one-cycle strobe and command
//   req0_done              requester-0 completion pulse
//   req1_valid/req1_data   requester-1 command, pushed when req1_valid && req1_ready
//   req1_ready             FIFO not full
//   req1_done              requester-1 completion pulse
//   i2c_exec/i2c_data      start strobe and held command to the I2C master
//   i2c_done               I2C master completion pulse
//   busy                   arbiter not idle
//   timeout                watchdog abort pulse
//   arb_err                sticky: dropped req0 command or watchdog abort
module i2c_cmd_arb #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_exec,
  input  logic [15:0] req0_data,
  output logic        req0_done,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic        req1_done,
  output logic        i2c_exec,
  output logic [15:0] i2c_data,
  input  logic        i2c_done,
  output logic        busy,
  output logic        timeout,
  output logic        arb_err
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e      state_q;
  logic        grant_q;       // 0: requester 0, 1: requester 1
  logic        req0_pend_q;
  logic [15:0] req0_cmd_q;
  logic        exec_q;
  logic [15:0] data_q;
  logic        done0_q;
  logic        done1_q;
  logic        err_q;
  logic        wait_expired;

  // Requester-1 FIFO
  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] fifo_cnt_q;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  assign fifo_full  = (fifo_cnt_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt_q == '0);
  // Ready depends only on the registered count, so a push is refused at full
  // even when the arbiter pops in the same cycle.
  assign push       = req1_valid && !fifo_full;
  assign pop        = (state_q == StIdle) && !req0_pend_q && !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= req1_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt_q;
  logic        timeout_q;

  // Counts WAIT cycles from 0; held at 0 outside WAIT so each transfer starts fresh.
  assign wait_expired = (wait_cnt_q == TIMEOUT_CYC - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= 16'd0;
      timeout_q  <= 1'b0;
    end else begin
      if (state_q == StWait) begin
        wait_cnt_q <= wait_cnt_q + 16'd1;
      end else begin
        wait_cnt_q <= 16'd0;
      end
      // i2c_done on the expiry cycle wins: no abort.
      timeout_q <= (state_q == StWait) && !i2c_done && wait_expired;
    end
  end

  assign timeout = timeout_q;
`else
  assign wait_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      grant_q     <= 1'b0;
      req0_pend_q <= 1'b0;
      req0_cmd_q  <= 16'h0;
      exec_q      <= 1'b0;
      data_q      <= 16'h0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      exec_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;

      // A strobe while the slot is occupied (pending or in flight) is lost.
      if (req0_exec) begin
        if (req0_pend_q) begin
          err_q <= 1'b1;
        end else begin
          req0_pend_q <= 1'b1;
          req0_cmd_q  <= req0_data;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (req0_pend_q) begin
            grant_q <= 1'b0;
            data_q  <= req0_cmd_q;
            exec_q  <= 1'b1;
            state_q <= StIssue;
          end else if (!fifo_empty) begin
            grant_q <= 1'b1;
            data_q  <= fifo_mem[rd_ptr_q];
            exec_q  <= 1'b1;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          state_q <= StWait;
        end
        StWait: begin
          if (i2c_done || wait_expired) begin
            if (grant_q) begin
              done1_q <= 1'b1;
            end else begin
              done0_q     <= 1'b1;
              req0_pend_q <= 1'b0;
            end
            if (!i2c_done) begin
              err_q <= 1'b1;
            end
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign req0_done  = done0_q;
  assign req1_done  = done1_q;
  assign req1_ready = !fifo_full;
  assign i2c_exec   = exec_q;
  assign i2c_data   = data_q;
  assign busy       = (state_q != StIdle);
  assign arb_err    = err_q;

endmodule

// File: tb/tb_i2c_cmd_arb.sv
// Self-checking bench for i2c_cmd_arb: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// transaction-level model (FIFO as a queue, transfer as an age counter).
module tb_i2c_cmd_arb;

  localparam int unsigned Depth = 4;
  localparam logic [15:0] ToCyc = 16'd16;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_exec = 1'b0;
  logic [15:0] req0_data = 16'h0;
  logic        req0_done;
  logic        req1_valid = 1'b0;
  logic [15:0] req1_data = 16'h0;
  logic        req1_ready;
  logic        req1_done;
  logic        i2c_exec;
  logic [15:0] i2c_data;
  logic        i2c_done = 1'b0;
  logic        busy;
  logic        timeout;
  logic        arb_err;

  i2c_cmd_arb #(
    .FIFO_DEPTH (Depth),
    .TIMEOUT_CYC(ToCyc)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_exec (req0_exec),
    .req0_data (req0_data),
    .req0_done (req0_done),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .req1_done (req1_done),
    .i2c_exec  (i2c_exec),
    .i2c_data  (i2c_data),
    .i2c_done  (i2c_done),
    .busy      (busy),
    .timeout   (timeout),
    .arb_err   (arb_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) begin
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_q[$];
  bit          m_pend = 1'b0;
  logic [15:0] m_pend_cmd = 16'h0;
  bit          m_active = 1'b0;
  bit          m_grant = 1'b0;
  int          m_age = 0;    // 0: strobe cycle, n>=1: n-th cycle waiting for the master
  logic [15:0] m_data = 16'h0;
  bit          m_exec = 1'b0;
  bit          m_done0 = 1'b0;
  bit          m_done1 = 1'b0;
  bit          m_to = 1'b0;
  bit          m_err = 1'b0;
  bit          m_push;
  bit          m_acc0;
  bit          m_end;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_pend = 0; m_pend_cmd = 16'h0; m_active = 0; m_grant = 0; m_age = 0;
      m_data = 16'h0; m_exec = 0; m_done0 = 0; m_done1 = 0; m_to = 0; m_err = 0;
    end else begin
      m_push = req1_valid && (m_q.size() < Depth);
      m_acc0 = req0_exec && !m_pend;
      if (req0_exec && m_pend) m_err = 1;
      m_exec = 0; m_done0 = 0; m_done1 = 0; m_to = 0; m_end = 0;
      if (!m_active) begin
        if (m_pend) begin
          m_active = 1; m_grant = 0; m_data = m_pend_cmd; m_age = 0; m_exec = 1;
        end else if (m_q.size() > 0) begin
          m_active = 1; m_grant = 1; m_data = m_q.pop_front(); m_age = 0; m_exec = 1;
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (i2c_done) begin
        m_end = 1;
      end else if (ToEn && m_age == int'(ToCyc)) begin
        m_end = 1; m_to = 1; m_err = 1;
      end else begin
        m_age++;
      end
      if (m_end) begin
        m_active = 0;
        if (m_grant) m_done1 = 1;
        else begin m_done0 = 1; m_pend = 0; end
      end
      if (m_acc0) begin m_pend = 1; m_pend_cmd = req0_data; end
      if (m_push) m_q.push_back(req1_data);
    end
  end

  always @(negedge clk) begin
    chk("m i2c_exec", i2c_exec, m_exec);
    chk("m i2c_data", i2c_data, m_data);
    chk("m req0_done", req0_done, m_done0);
    chk("m req1_done", req1_done, m_done1);
    chk("m busy", busy, m_active);
    chk("m timeout", timeout, m_to);
    chk("m arb_err", arb_err, m_err);
    chk("m req1_ready", req1_ready, m_q.size() < Depth);
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    req0_exec = 0; req1_valid = 0; i2c_done = 0;
    #2 rst_n = 0;
    @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst ready", req1_ready, 1);
    chk("rst data", i2c_data, 16'h0);
    chk("rst err", arb_err, 0);
    chk("rst exec", i2c_exec, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wait_exec(input string name, input logic [15:0] exp_data);
    int lat;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i2c_exec) begin
        lat = i;
        break;
      end
    end
    vectors++;
    if (lat < 0) begin
      errors++;
      $display("FAIL %s: no i2c_exec within 60 cycles, expected data %h", name, exp_data);
    end else begin
      chk(name, i2c_data, exp_data);
    end
  endtask

  // Waits dly cycles, pulses i2c_done, returns on the cycle the done pulse is due.
  task automatic pulse_done(input int dly);
    repeat (dly) @(negedge clk);
    i2c_done = 1;
    @(negedge clk);
    i2c_done = 0;
  endtask

  task automatic push1(input logic [15:0] d);
    req1_valid = 1; req1_data = d;
    @(negedge clk);
    req1_valid = 0;
  endtask

  initial begin
    int n_exec;
    int resp;

    repeat (2) @(negedge clk);
    chk("init busy", busy, 0);
    chk("init ready", req1_ready, 1);
    chk("init data", i2c_data, 16'h0);
    rst_n = 1;

    // T1: req0 latency and completion
    @(negedge clk);
    req0_exec = 1; req0_data = 16'h1280;
    @(negedge clk);
    req0_exec = 0;
    chk("t1 exec at +1", i2c_exec, 0);
    @(negedge clk);
    chk("t1 exec at +2", i2c_exec, 1);
    chk("t1 data", i2c_data, 16'h1280);
    chk("t1 busy", busy, 1);
    pulse_done(100);
    chk("t1 req0_done", req0_done, 1);
    chk("t1 busy after", busy, 0);
    @(negedge clk);
    chk("t1 req0_done once", req0_done, 0);

    // T2: five back-to-back pushes with master stalled
    for (int k = 1; k <= 5; k++) begin
      req1_valid = 1; req1_data = {8'(k), 8'(k)};
      @(negedge clk);
      chk("t2 ready", req1_ready, (k < 5));
      if (k == 2) chk("t2 first exec", i2c_exec, 1);
    end
    req1_data = 16'h0606;
    repeat (3) begin
      @(negedge clk);
      chk("t2 ready full", req1_ready, 0);
    end
    req1_valid = 0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) wait_exec("t2 order", {8'(k), 8'(k)});
      else chk("t2 data 1", i2c_data, 16'h0101);
      pulse_done(3);
      chk("t2 req1_done", req1_done, 1);
    end
    repeat (10) @(negedge clk);
    chk("t2 drained busy", busy, 0);
    chk("t2 drained ready", req1_ready, 1);

    // T3: req0 jumps queued req1 but does not preempt
    push1(16'hA001);
    wait_exec("t3 first", 16'hA001);
    @(negedge clk);
    req0_exec = 1; req0_data = 16'hB0B0; req1_valid = 1; req1_data = 16'hA002;
    @(negedge clk);
    req0_exec = 0; req1_data = 16'hA003;
    @(negedge clk);
    req1_valid = 0;
    chk("t3 still busy", busy, 1);
    pulse_done(3);
    chk("t3 req1_done", req1_done, 1);
    wait_exec("t3 req0 next", 16'hB0B0);
    pulse_done(2);
    chk("t3 req0_done", req0_done, 1);
    wait_exec("t3 then A002", 16'hA002);
    pulse_done(2);
    wait_exec("t3 then A003", 16'hA003);
    pulse_done(2);
    chk("t3 last done", req1_done, 1);

    // T6: reset during WAIT with two queued entries
    req1_valid = 1; req1_data = 16'hD001;
    @(negedge clk); req1_data = 16'hD002;
    @(negedge clk); req1_data = 16'hD003;
    @(negedge clk); req1_valid = 0;
    repeat (3) @(negedge clk);
    chk("t6 busy pre", busy, 1);
    chk("t6 data pre", i2c_data, 16'hD001);
    do_reset();
    i2c_done = 1;
    @(negedge clk);
    i2c_done = 0;
    n_exec = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_exec += int'(i2c_exec) + int'(req0_done) + int'(req1_done);
    end
    chk("t6 no activity", 16'(n_exec), 16'd0);
    chk("t6 busy", busy, 0);

`ifdef I2C_ARB_TIMEOUT_EN
    // T5: watchdog expiry and done-on-last-cycle precedence
    push1(16'hC0DE);
    wait_exec("t5 exec", 16'hC0DE);
    repeat (16) @(negedge clk);
    chk("t5 no timeout yet", timeout, 0);
    chk("t5 busy", busy, 1);
    @(negedge clk);
    chk("t5 timeout", timeout, 1);
    chk("t5 req1_done", req1_done, 1);
    chk("t5 arb_err", arb_err, 1);
    chk("t5 idle", busy, 0);
    do_reset();
    push1(16'hC0DF);
    wait_exec("t5b exec", 16'hC0DF);
    repeat (15) @(negedge clk);
    pulse_done(1);
    chk("t5b req1_done", req1_done, 1);
    chk("t5b no timeout", timeout, 0);
    chk("t5b no err", arb_err, 0);
`endif

    // T4: second req0 while in flight is dropped
    req0_exec = 1; req0_data = 16'h1111;
    @(negedge clk);
    req0_exec = 0;
    wait_exec("t4 exec", 16'h1111);
    @(negedge clk);
    req0_exec = 1; req0_data = 16'h2222;
    @(negedge clk);
    req0_exec = 0;
    chk("t4 arb_err", arb_err, 1);
    pulse_done(2);
    chk("t4 req0_done", req0_done, 1);
    n_exec = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_exec += int'(i2c_exec);
    end
    chk("t4 single exec", 16'(n_exec), 16'd0);
    chk("t4 data held", i2c_data, 16'h1111);
    chk("t4 err sticky", arb_err, 1);
    do_reset();

    // Randomized traffic; the responder answers each strobe after 1..23 cycles
    resp = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      i2c_done = 0;
      if (i2c_exec) resp = $urandom_range(2, 24);
      if (resp > 0) begin
        resp--;
        if (resp == 0) i2c_done = 1;
      end else if ($urandom_range(0, 49) == 0) begin
        i2c_done = 1;
      end
      req0_exec  = ($urandom_range(0, 24) == 0);
      req0_data  = 16'($urandom);
      req1_valid = ($urandom_range(0, 2) == 0);
      req1_data  = 16'($urandom);
    end
    req0_exec = 0; req1_valid = 0; i2c_done = 0;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, %0d miscompares so far", errors);
    $fatal(1);
  end

endmodule

// File: doc/i2c_cmd_arb.md
I2C_CMD_ARB -- requirements
Module: i2c_cmd_arb

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, which sets the requester-1 command FIFO depth (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 16'd50000, which sets the number of WAIT-state cycles before a transfer aborts.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req0_exec  input  1  config-sequencer command strobe, one cycle.
REQ-006 SHALL have port req0_data  input  16  config command, {reg addr[15:8], data[7:0]}, valid with req0_exec.
REQ-007 SHALL have port req0_done  output  1  one-cycle completion pulse for requester 0.
REQ-008 SHALL have port req1_valid  input  1  runtime command valid.
REQ-009 SHALL have port req1_data  input  16  runtime command, same format as req0_data.
REQ-010 SHALL have port req1_ready  output  1  FIFO can accept; a push occurs when req1_valid && req1_ready.
REQ-011 SHALL have port req1_done  output  1  one-cycle completion pulse for requester 1.
REQ-012 SHALL have port i2c_exec  output  1  one-cycle start strobe to the I2C master.
REQ-013 SHALL have port i2c_data  output  16  command to the I2C master, held stable from i2c_exec until i2c_done.
REQ-014 SHALL have port i2c_done  input  1  I2C master completion pulse.
REQ-015 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-016 SHALL have port timeout  output  1  one-cycle pulse when a transfer is aborted by the watchdog.
REQ-017 SHALL have port arb_err  output  1  sticky error flag.

Function
REQ-018 SHALL latch req0_data into a pending slot on req0_exec and set req0_pend.
REQ-019 SHALL drop a req0_exec that arrives while req0 is pending or in flight, and SHALL set arb_err.
REQ-020 SHALL push req1 commands into a FIFO of FIFO_DEPTH entries, with req1_ready = !full.
REQ-021 SHALL block a push at full even when a pop occurs in the same cycle.
REQ-022 SHALL wrap the FIFO pointers modulo FIFO_DEPTH, and SHALL leave the count unchanged on a simultaneous push and pop when not full.
REQ-023 SHALL implement states IDLE, ISSUE and WAIT.
REQ-024 In IDLE, SHALL go to ISSUE when req0_pend is set (grant 0, fixed priority); otherwise SHALL go to ISSUE when the FIFO is not empty (grant 1, pop head); otherwise SHALL stay in IDLE.
REQ-025 In ISSUE, SHALL drive i2c_exec=1 for exactly one cycle with i2c_data = the granted command, then go to WAIT.
REQ-026 In WAIT, on i2c_done, SHALL pulse the granted reqX_done the next cycle, clear req0_pend if grant 0, and return to IDLE.
REQ-027 SHALL ignore i2c_done outside WAIT.
REQ-028 SHALL not preempt: a req0 arriving during a req1 transfer waits for that transfer to complete.
REQ-029 With the arbiter IDLE, SHALL assert i2c_exec 2 cycles after req0_exec or after the first req1 push.
REQ-030 SHALL assert the next i2c_exec no earlier than 2 cycles after i2c_done.
REQ-031 SHALL hold i2c_data at its last value when not driving a new command.

Reset
REQ-032 On rst_n low, SHALL enter IDLE, empty the FIFO and clear req0_pend.
REQ-033 On rst_n low, SHALL set i2c_exec, req0_done, req1_done, busy, timeout, arb_err = 0, i2c_data = 16'h0 and req1_ready = 1.
REQ-034 Reset mid-transfer SHALL abort the transfer with no done pulse, and any i2c_done arriving after reset release SHALL be ignored while IDLE.

Configuration
REQ-035 With macro I2C_ARB_TIMEOUT_EN defined, SHALL count cycles in WAIT from 0.
REQ-036 With I2C_ARB_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYC-1 without i2c_done, SHALL pulse timeout and the granted reqX_done together, set arb_err, clear req0_pend if grant 0, and return to IDLE.
REQ-037 With I2C_ARB_TIMEOUT_EN defined, i2c_done on that same cycle SHALL take precedence, with no timeout.
REQ-038 Without I2C_ARB_TIMEOUT_EN, WAIT SHALL last indefinitely, timeout SHALL be tied to 0, and no counter SHALL be instantiated.

Verification
REQ-039 Bench SHALL cover: req0_exec with req0_data=16'h1280 while IDLE -> i2c_exec 2 cycles later with i2c_data=16'h1280; i2c_done after 100 cycles -> req0_done 1 cycle later, busy low.
REQ-040 Bench SHALL cover: 5 req1 pushes back-to-back with the master stalled (no i2c_done) -> first popped, next 4 fill the FIFO, req1_ready=0 after the 4th stored entry, 5th held; done pulses release entries in order 1..5.
REQ-041 Bench SHALL cover: req1 transfer in WAIT plus req0_exec and 2 queued req1 -> after i2c_done the next i2c_exec carries the req0 command, then the req1 commands.
REQ-042 Bench SHALL cover: second req0_exec while req0 is in flight -> dropped, arb_err=1, only one i2c_exec.
REQ-043 Bench SHALL cover, with I2C_ARB_TIMEOUT_EN and TIMEOUT_CYC=16: no i2c_done -> timeout and req1_done pulse together after 16 WAIT cycles, arb_err=1; and i2c_done on cycle 16 -> no timeout.
REQ-044 Bench SHALL cover: rst_n pulsed low during WAIT with 2 FIFO entries -> IDLE, FIFO empty, no done pulse, a following i2c_done ignored.
